// File: rtl/mips_pkg.sv
// Shared encodings for the multicycle MIPS controller: opcodes, function
// codes, ALU control codes, FSM state encoding and datapath select codes.
package mips_pkg;

  // Primary opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type function codes (IR[5:0])
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  // ALU operation codes
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // ALU B-input select codes
  localparam logic [1:0] SRCB_REG   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  // PC source select codes
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Controller states, 4-bit binary
  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_RTEXEC  = 4'd6,
    S_ALUWB   = 4'd7,
    S_IMMEXEC = 4'd8,
    S_BRANCH  = 4'd9,
    S_JUMP    = 4'd10
  } state_e;

  // Which kind of ALU operation the current state wants
  typedef enum logic [1:0] {
    CLS_ADD   = 2'b00,
    CLS_SUB   = 2'b01,
    CLS_FUNCT = 2'b10,
    CLS_IMM   = 2'b11
  } alu_cls_e;

  // Map an R-type function code to {unsupported flag, ALU code}.
  // Unsupported codes fall back to add so the ALU stays in a benign mode.
  function automatic logic [3:0] funct_decode(input logic [5:0] funct);
    logic [3:0] res;
    case (funct)
      FN_ADD:  res = {1'b0, ALU_ADD};
      FN_SUB:  res = {1'b0, ALU_SUB};
      FN_AND:  res = {1'b0, ALU_AND};
      FN_OR:   res = {1'b0, ALU_OR};
      FN_SLT:  res = {1'b0, ALU_SLT};
      default: res = {1'b1, ALU_ADD};
    endcase
    return res;
  endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: turns the state's ALU class plus Op/Funct into the ALU
// operation, the immediate extension mode and an unsupported-Funct flag.
module mc_aludec
  import mips_pkg::*;
(
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic [1:0] cls_i,
  output logic [2:0] alu_ctl_o,
  output logic       ext_op_o,
  output logic       funct_illegal_o
);

  logic [3:0] funct_dec_s;

  // Function-code lookup, shared by RTEXEC control and DECODE legality check
  always_comb begin
    funct_dec_s     = funct_decode(funct_i);
    funct_illegal_o = funct_dec_s[3];
  end

  // ALU operation and immediate extension selected by ALU class
  always_comb begin
    alu_ctl_o = ALU_ADD;
    ext_op_o  = 1'b1;
    case (cls_i)
      CLS_ADD:   alu_ctl_o = ALU_ADD;
      CLS_SUB:   alu_ctl_o = ALU_SUB;
      CLS_FUNCT: alu_ctl_o = funct_dec_s[2:0];
      CLS_IMM: begin
        case (op_i)
          OP_ADDI: begin alu_ctl_o = ALU_ADD; ext_op_o = 1'b1; end
          OP_ANDI: begin alu_ctl_o = ALU_AND; ext_op_o = 1'b0; end
          OP_ORI:  begin alu_ctl_o = ALU_OR;  ext_op_o = 1'b0; end
          OP_SLTI: begin alu_ctl_o = ALU_SLT; ext_op_o = 1'b1; end
          default: begin alu_ctl_o = ALU_ADD; ext_op_o = 1'b1; end
        endcase
      end
      default:   alu_ctl_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM. Registered state, combinational outputs from
// state plus Op/Funct/Zero/MemReady. All strobes and selects are held in
// their idle values while reset_n is low so nothing fires during reset.
module multicycle_controller
  import mips_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] Op,
  input  logic [5:0] Funct,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemToReg,
  output logic       RegWrite,
  output logic       AluSrcA,
  output logic [1:0] AluSrcB,
  output logic [2:0] AluCtl,
  output logic       ExtOp,
  output logic [1:0] PCSrc,
  output logic       PCEn,
  output logic       InstrDone,
  output logic       Illegal
);

  state_e     state_q, state_d;

  logic       iord_s, mem_read_s, mem_write_s, ir_write_s;
  logic       reg_dst_s, mem_to_reg_s, reg_write_s, alu_src_a_s;
  logic [1:0] alu_src_b_s, pc_src_s;
  logic       pc_en_s, instr_done_s, illegal_s;
  logic [1:0] alu_cls_s;
  logic [2:0] alu_ctl_s;
  logic       ext_op_s;
  logic       funct_illegal_s;

  mc_aludec u_aludec (
    .op_i            (Op),
    .funct_i         (Funct),
    .cls_i           (alu_cls_s),
    .alu_ctl_o       (alu_ctl_s),
    .ext_op_o        (ext_op_s),
    .funct_illegal_o (funct_illegal_s)
  );

  // State register; reset returns to FETCH immediately, aborting any instruction
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-state control decode
  always_comb begin
    state_d      = state_q;
    iord_s       = 1'b0;
    mem_read_s   = 1'b0;
    mem_write_s  = 1'b0;
    ir_write_s   = 1'b0;
    reg_dst_s    = 1'b0;
    mem_to_reg_s = 1'b0;
    reg_write_s  = 1'b0;
    alu_src_a_s  = 1'b0;
    alu_src_b_s  = SRCB_REG;
    pc_src_s     = PCSRC_ALU;
    pc_en_s      = 1'b0;
    instr_done_s = 1'b0;
    illegal_s    = 1'b0;
    alu_cls_s    = CLS_ADD;

    case (state_q)
      S_FETCH: begin
        mem_read_s  = 1'b1;
        alu_src_b_s = SRCB_FOUR;
        ir_write_s  = MemReady;
        pc_en_s     = MemReady;
        if (MemReady) begin
          state_d = S_DECODE;
        end else begin
          state_d = S_FETCH;
        end
      end

      S_DECODE: begin
        // Precompute the branch target into ALUOut
        alu_src_b_s = SRCB_IMMSH;
        case (Op)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE: begin
            if (funct_illegal_s) begin
              illegal_s = 1'b1;
              state_d   = S_FETCH;
            end else begin
              state_d   = S_RTEXEC;
            end
          end
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_IMMEXEC;
          OP_BEQ, OP_BNE: state_d = S_BRANCH;
          OP_J:           state_d = S_JUMP;
          default: begin
            illegal_s = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end

      S_MEMADR: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRCB_IMM;
        if (Op == OP_LW) begin
          state_d = S_MEMRD;
        end else begin
          state_d = S_MEMWR;
        end
      end

      S_MEMRD: begin
        mem_read_s = 1'b1;
        iord_s     = 1'b1;
        if (MemReady) begin
          state_d = S_MEMWB;
        end else begin
          state_d = S_MEMRD;
        end
      end

      S_MEMWB: begin
        reg_write_s  = 1'b1;
        mem_to_reg_s = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end

      S_MEMWR: begin
        mem_write_s  = 1'b1;
        iord_s       = 1'b1;
        instr_done_s = MemReady;
        if (MemReady) begin
          state_d = S_FETCH;
        end else begin
          state_d = S_MEMWR;
        end
      end

      S_RTEXEC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRCB_REG;
        alu_cls_s   = CLS_FUNCT;
        state_d     = S_ALUWB;
      end

      S_ALUWB: begin
        reg_write_s  = 1'b1;
        instr_done_s = 1'b1;
        // R-type writes rd, immediate forms write rt
        reg_dst_s    = (Op == OP_RTYPE);
        state_d      = S_FETCH;
      end

      S_IMMEXEC: begin
        alu_src_a_s = 1'b1;
        alu_src_b_s = SRCB_IMM;
        alu_cls_s   = CLS_IMM;
        state_d     = S_ALUWB;
      end

      S_BRANCH: begin
        alu_src_a_s  = 1'b1;
        alu_src_b_s  = SRCB_REG;
        alu_cls_s    = CLS_SUB;
        pc_src_s     = PCSRC_ALUOUT;
        instr_done_s = 1'b1;
        pc_en_s      = Zero ^ (Op == OP_BNE);
        state_d      = S_FETCH;
      end

      S_JUMP: begin
        pc_src_s     = PCSRC_JUMP;
        pc_en_s      = 1'b1;
        instr_done_s = 1'b1;
        state_d      = S_FETCH;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Output drive, forced to idle values while reset is asserted
  always_comb begin
    if (!reset_n) begin
      IorD      = 1'b0;
      MemRead   = 1'b0;
      MemWrite  = 1'b0;
      IRWrite   = 1'b0;
      RegDst    = 1'b0;
      MemToReg  = 1'b0;
      RegWrite  = 1'b0;
      AluSrcA   = 1'b0;
      AluSrcB   = 2'b00;
      AluCtl    = ALU_ADD;
      ExtOp     = 1'b1;
      PCSrc     = 2'b00;
      PCEn      = 1'b0;
      InstrDone = 1'b0;
      Illegal   = 1'b0;
    end else begin
      IorD      = iord_s;
      MemRead   = mem_read_s;
      MemWrite  = mem_write_s;
      IRWrite   = ir_write_s;
      RegDst    = reg_dst_s;
      MemToReg  = mem_to_reg_s;
      RegWrite  = reg_write_s;
      AluSrcA   = alu_src_a_s;
      AluSrcB   = alu_src_b_s;
      AluCtl    = alu_ctl_s;
      ExtOp     = ext_op_s;
      PCSrc     = pc_src_s;
      PCEn      = pc_en_s;
      InstrDone = instr_done_s;
      Illegal   = illegal_s;
    end
  end

endmodule

// File: tb/tb_multicycle_controller.sv
// Self-checking bench for multicycle_controller. Each scenario queues
// per-cycle stimulus with the expected control word, then replays the queue
// and compares the DUT outputs at the falling edge.
module tb_multicycle_controller;

  typedef struct packed {
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctl;
    logic       ext_op;
    logic [1:0] pc_src;
    logic       pc_en;
    logic       instr_done;
    logic       illegal;
  } ctl_t;

  typedef struct {
    logic [5:0] op;
    logic [5:0] funct;
    logic       mr;
    logic       z;
    ctl_t       exp;
    string      name;
  } stim_t;

  logic       clk;
  logic       reset_n;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       MemReady;
  logic       IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite, AluSrcA;
  logic [1:0] AluSrcB;
  logic [2:0] AluCtl;
  logic       ExtOp;
  logic [1:0] PCSrc;
  logic       PCEn, InstrDone, Illegal;

  ctl_t  dut_ctl;
  stim_t sb[$];
  stim_t cur;
  int    total;
  int    passed;

  multicycle_controller dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .Op        (Op),
    .Funct     (Funct),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .IorD      (IorD),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .IRWrite   (IRWrite),
    .RegDst    (RegDst),
    .MemToReg  (MemToReg),
    .RegWrite  (RegWrite),
    .AluSrcA   (AluSrcA),
    .AluSrcB   (AluSrcB),
    .AluCtl    (AluCtl),
    .ExtOp     (ExtOp),
    .PCSrc     (PCSrc),
    .PCEn      (PCEn),
    .InstrDone (InstrDone),
    .Illegal   (Illegal)
  );

  assign dut_ctl = {IorD, MemRead, MemWrite, IRWrite, RegDst, MemToReg, RegWrite,
                    AluSrcA, AluSrcB, AluCtl, ExtOp, PCSrc, PCEn, InstrDone, Illegal};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected control words, written directly from the per-state output lists
  function automatic ctl_t e_idle();
    ctl_t v;
    v = '0;
    v.alu_ctl = 3'b010;
    v.ext_op  = 1'b1;
    return v;
  endfunction

  function automatic ctl_t e_fetch(input logic mr);
    ctl_t v;
    v = e_idle();
    v.mem_read = 1'b1; v.alu_src_b = 2'b01; v.ir_write = mr; v.pc_en = mr;
    return v;
  endfunction

  function automatic ctl_t e_decode(input logic ill);
    ctl_t v;
    v = e_idle();
    v.alu_src_b = 2'b11; v.illegal = ill;
    return v;
  endfunction

  function automatic ctl_t e_memadr();
    ctl_t v;
    v = e_idle();
    v.alu_src_a = 1'b1; v.alu_src_b = 2'b10;
    return v;
  endfunction

  function automatic ctl_t e_memrd();
    ctl_t v;
    v = e_idle();
    v.mem_read = 1'b1; v.iord = 1'b1;
    return v;
  endfunction

  function automatic ctl_t e_memwb();
    ctl_t v;
    v = e_idle();
    v.reg_write = 1'b1; v.mem_to_reg = 1'b1; v.instr_done = 1'b1;
    return v;
  endfunction

  function automatic ctl_t e_memwr(input logic mr);
    ctl_t v;
    v = e_idle();
    v.mem_write = 1'b1; v.iord = 1'b1; v.instr_done = mr;
    return v;
  endfunction

  function automatic ctl_t e_exec(input logic [1:0] srcb, input logic [2:0] c, input logic e);
    ctl_t v;
    v = e_idle();
    v.alu_src_a = 1'b1; v.alu_src_b = srcb; v.alu_ctl = c; v.ext_op = e;
    return v;
  endfunction

  function automatic ctl_t e_aluwb(input logic rd);
    ctl_t v;
    v = e_idle();
    v.reg_write = 1'b1; v.instr_done = 1'b1; v.reg_dst = rd;
    return v;
  endfunction

  function automatic ctl_t e_branch(input logic pe);
    ctl_t v;
    v = e_idle();
    v.alu_src_a = 1'b1; v.alu_src_b = 2'b00; v.alu_ctl = 3'b110;
    v.pc_src = 2'b01; v.instr_done = 1'b1; v.pc_en = pe;
    return v;
  endfunction

  function automatic ctl_t e_jump();
    ctl_t v;
    v = e_idle();
    v.pc_src = 2'b10; v.pc_en = 1'b1; v.instr_done = 1'b1;
    return v;
  endfunction

  task automatic push(input logic [5:0] op, input logic [5:0] fn, input logic mr,
                      input logic z, input ctl_t exp, input string name);
    stim_t s;
    s.op = op; s.funct = fn; s.mr = mr; s.z = z; s.exp = exp; s.name = name;
    sb.push_back(s);
  endtask

  // Apply one queued stimulus and wait for the sampling point
  task automatic apply_next();
    cur = sb.pop_front();
    Op = cur.op; Funct = cur.funct; MemReady = cur.mr; Zero = cur.z;
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset_n = 1'b0; MemReady = 1'b1; Op = 6'b000000; Funct = 6'b000000; Zero = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (dut_ctl !== e_idle()) $display("FAIL reset_hold: got %b expected %b", dut_ctl, e_idle());
    else passed++;
    MemReady = 1'b0;
    reset_n  = 1'b1;
    #1;
    total++;
    if (dut_ctl !== e_fetch(1'b0)) $display("FAIL fetch_stall: got %b expected %b", dut_ctl, e_fetch(1'b0));
    else passed++;
    MemReady = 1'b1;
    #1;
    total++;
    if (dut_ctl !== e_fetch(1'b1)) $display("FAIL fetch_ready: got %b expected %b", dut_ctl, e_fetch(1'b1));
    else passed++;
    MemReady = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_lw();
    push(6'b100011, 6'b000000, 1'b0, 1'b0, e_fetch(1'b0), "lw_fetch_wait");
    push(6'b100011, 6'b000000, 1'b1, 1'b0, e_fetch(1'b1), "lw_fetch");
    push(6'b100011, 6'b000000, 1'b1, 1'b0, e_decode(1'b0), "lw_decode");
    push(6'b100011, 6'b000000, 1'b1, 1'b0, e_memadr(), "lw_memadr");
    push(6'b100011, 6'b000000, 1'b1, 1'b0, e_memrd(), "lw_memrd");
    push(6'b100011, 6'b000000, 1'b1, 1'b0, e_memwb(), "lw_memwb");
    push(6'b100011, 6'b000000, 1'b0, 1'b0, e_fetch(1'b0), "lw_back_fetch");
    while (sb.size() > 0) begin
      apply_next();
      total++;
      if (dut_ctl !== cur.exp) $display("FAIL %s: got %b expected %b", cur.name, dut_ctl, cur.exp);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_sw_stall();
    push(6'b101011, 6'b000000, 1'b1, 1'b0, e_fetch(1'b1), "sw_fetch");
    push(6'b101011, 6'b000000, 1'b1, 1'b0, e_decode(1'b0), "sw_decode");
    push(6'b101011, 6'b000000, 1'b1, 1'b0, e_memadr(), "sw_memadr");
    for (int i = 0; i < 3; i++) push(6'b101011, 6'b000000, 1'b0, 1'b0, e_memwr(1'b0), "sw_memwr_wait");
    push(6'b101011, 6'b000000, 1'b1, 1'b0, e_memwr(1'b1), "sw_memwr_done");
    push(6'b101011, 6'b000000, 1'b0, 1'b0, e_fetch(1'b0), "sw_back_fetch");
    while (sb.size() > 0) begin
      apply_next();
      total++;
      if (dut_ctl !== cur.exp) $display("FAIL %s: got %b expected %b", cur.name, dut_ctl, cur.exp);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_rtype();
    push(6'b000000, 6'b100010, 1'b1, 1'b0, e_fetch(1'b1), "sub_fetch");
    push(6'b000000, 6'b100010, 1'b1, 1'b0, e_decode(1'b0), "sub_decode");
    push(6'b000000, 6'b100010, 1'b1, 1'b0, e_exec(2'b00, 3'b110, 1'b1), "sub_rtexec");
    push(6'b000000, 6'b100010, 1'b1, 1'b0, e_aluwb(1'b1), "sub_aluwb");
    push(6'b000000, 6'b101010, 1'b1, 1'b0, e_fetch(1'b1), "slt_fetch");
    push(6'b000000, 6'b101010, 1'b1, 1'b0, e_decode(1'b0), "slt_decode");
    push(6'b000000, 6'b101010, 1'b1, 1'b0, e_exec(2'b00, 3'b111, 1'b1), "slt_rtexec");
    push(6'b000000, 6'b101010, 1'b1, 1'b0, e_aluwb(1'b1), "slt_aluwb");
    push(6'b000000, 6'b100101, 1'b1, 1'b0, e_fetch(1'b1), "or_fetch");
    push(6'b000000, 6'b100101, 1'b1, 1'b0, e_decode(1'b0), "or_decode");
    push(6'b000000, 6'b100101, 1'b1, 1'b0, e_exec(2'b00, 3'b001, 1'b1), "or_rtexec");
    push(6'b000000, 6'b100101, 1'b1, 1'b0, e_aluwb(1'b1), "or_aluwb");
    push(6'b000000, 6'b100101, 1'b0, 1'b0, e_fetch(1'b0), "rtype_back_fetch");
    while (sb.size() > 0) begin
      apply_next();
      total++;
      if (dut_ctl !== cur.exp) $display("FAIL %s: got %b expected %b", cur.name, dut_ctl, cur.exp);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_branch_jump();
    push(6'b000100, 6'b000000, 1'b1, 1'b1, e_fetch(1'b1), "beq_fetch");
    push(6'b000100, 6'b000000, 1'b1, 1'b1, e_decode(1'b0), "beq_decode");
    push(6'b000100, 6'b000000, 1'b1, 1'b1, e_branch(1'b1), "beq_taken");
    push(6'b000100, 6'b000000, 1'b1, 1'b0, e_fetch(1'b1), "beq_nt_fetch");
    push(6'b000100, 6'b000000, 1'b1, 1'b0, e_decode(1'b0), "beq_nt_decode");
    push(6'b000100, 6'b000000, 1'b1, 1'b0, e_branch(1'b0), "beq_not_taken");
    push(6'b000101, 6'b000000, 1'b1, 1'b1, e_fetch(1'b1), "bne_fetch");
    push(6'b000101, 6'b000000, 1'b1, 1'b1, e_decode(1'b0), "bne_decode");
    push(6'b000101, 6'b000000, 1'b1, 1'b1, e_branch(1'b0), "bne_zero");
    push(6'b000010, 6'b000000, 1'b1, 1'b0, e_fetch(1'b1), "j_fetch");
    push(6'b000010, 6'b000000, 1'b1, 1'b0, e_decode(1'b0), "j_decode");
    push(6'b000010, 6'b000000, 1'b1, 1'b0, e_jump(), "j_jump");
    push(6'b000010, 6'b000000, 1'b0, 1'b0, e_fetch(1'b0), "j_back_fetch");
    while (sb.size() > 0) begin
      apply_next();
      total++;
      if (dut_ctl !== cur.exp) $display("FAIL %s: got %b expected %b", cur.name, dut_ctl, cur.exp);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_immediate();
    push(6'b001101, 6'b000000, 1'b1, 1'b0, e_fetch(1'b1), "ori_fetch");
    push(6'b001101, 6'b000000, 1'b1, 1'b0, e_decode(1'b0), "ori_decode");
    push(6'b001101, 6'b000000, 1'b1, 1'b0, e_exec(2'b10, 3'b001, 1'b0), "ori_immexec");
    push(6'b001101, 6'b000000, 1'b1, 1'b0, e_aluwb(1'b0), "ori_aluwb");
    push(6'b001010, 6'b000000, 1'b1, 1'b0, e_fetch(1'b1), "slti_fetch");
    push(6'b001010, 6'b000000, 1'b1, 1'b0, e_decode(1'b0), "slti_decode");
    push(6'b001010, 6'b000000, 1'b1, 1'b0, e_exec(2'b10, 3'b111, 1'b1), "slti_immexec");
    push(6'b001010, 6'b000000, 1'b1, 1'b0, e_aluwb(1'b0), "slti_aluwb");
    push(6'b001100, 6'b000000, 1'b1, 1'b0, e_fetch(1'b1), "andi_fetch");
    push(6'b001100, 6'b000000, 1'b1, 1'b0, e_decode(1'b0), "andi_decode");
    push(6'b001100, 6'b000000, 1'b1, 1'b0, e_exec(2'b10, 3'b000, 1'b0), "andi_immexec");
    push(6'b001100, 6'b000000, 1'b1, 1'b0, e_aluwb(1'b0), "andi_aluwb");
    push(6'b001100, 6'b000000, 1'b0, 1'b0, e_fetch(1'b0), "imm_back_fetch");
    while (sb.size() > 0) begin
      apply_next();
      total++;
      if (dut_ctl !== cur.exp) $display("FAIL %s: got %b expected %b", cur.name, dut_ctl, cur.exp);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_illegal();
    push(6'b111111, 6'b000000, 1'b1, 1'b0, e_fetch(1'b1), "badop_fetch");
    push(6'b111111, 6'b000000, 1'b1, 1'b0, e_decode(1'b1), "badop_decode");
    push(6'b111111, 6'b000000, 1'b1, 1'b0, e_fetch(1'b1), "badop_refetch");
    push(6'b000000, 6'b000111, 1'b1, 1'b0, e_decode(1'b1), "badfn_decode");
    push(6'b000000, 6'b000111, 1'b0, 1'b0, e_fetch(1'b0), "badfn_back_fetch");
    while (sb.size() > 0) begin
      apply_next();
      total++;
      if (dut_ctl !== cur.exp) $display("FAIL %s: got %b expected %b", cur.name, dut_ctl, cur.exp);
      else passed++;
      @(posedge clk); #1;
    end
  endtask

  task automatic test_reset_midinstr();
    push(6'b100011, 6'b000000, 1'b1, 1'b0, e_fetch(1'b1), "abort_fetch");
    push(6'b100011, 6'b000000, 1'b1, 1'b0, e_decode(1'b0), "abort_decode");
    push(6'b100011, 6'b000000, 1'b1, 1'b0, e_memadr(), "abort_memadr");
    push(6'b100011, 6'b000000, 1'b0, 1'b0, e_memrd(), "abort_memrd");
    while (sb.size() > 0) begin
      apply_next();
      total++;
      if (dut_ctl !== cur.exp) $display("FAIL %s: got %b expected %b", cur.name, dut_ctl, cur.exp);
      else passed++;
      if (sb.size() > 0) begin
        @(posedge clk); #1;
      end else begin
        #2;
      end
    end
    // Drop reset mid-cycle while waiting in MEMRD with memory ready asserted
    MemReady = 1'b1;
    reset_n  = 1'b0;
    #1;
    total++;
    if (dut_ctl !== e_idle()) $display("FAIL abort_in_reset: got %b expected %b", dut_ctl, e_idle());
    else passed++;
    @(posedge clk); #1;
    total++;
    if (dut_ctl !== e_idle()) $display("FAIL abort_reset_edge: got %b expected %b", dut_ctl, e_idle());
    else passed++;
    @(negedge clk);
    MemReady = 1'b0;
    reset_n  = 1'b1;
    #1;
    total++;
    if (dut_ctl !== e_fetch(1'b0)) $display("FAIL abort_release_fetch: got %b expected %b", dut_ctl, e_fetch(1'b0));
    else passed++;
    @(posedge clk); #1;
    total++;
    if (RegWrite !== 1'b0) $display("FAIL abort_no_regwrite: got %b expected %b", RegWrite, 1'b0);
    else passed++;
  endtask

  initial begin
    total  = 0;
    passed = 0;
    test_reset();
    test_lw();
    test_sw_stall();
    test_rtype();
    test_branch_jump();
    test_immediate();
    test_illegal();
    test_reset_midinstr();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
